acorn128_host_if: RTL and testbench

//  Host-side front end for the ACORN-128 core. Collects key, IV, AD, text, length and expected tag as
//  32-bit word writes into 128-bit staging registers. On a command it drives and holds the core's start,

---
 rtl/acorn128_pkg.sv | 33 +++
 rtl/acorn128_word_stage.sv | 46 ++++
 rtl/acorn128_host_if.sv | 225 ++++++++++++++++++++++
 tb/tb_acorn128_host_if.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acorn128_pkg.sv
// ---------------------------------------------------------------------------
// acorn128_pkg
//   Shared definitions for the ACORN-128 host front end:
//     - ACORN_BLK_W / ACORN_LEN_W : staging register widths
//     - host_state_t              : host interface FSM states
//     - wr_sel_t                  : word-write field select codes
//     - ACORN_CNT_W               : width of the RUN-state cycle counter
// ---------------------------------------------------------------------------
package acorn128_pkg;

  localparam int ACORN_BLK_W = 128;
  localparam int ACORN_LEN_W = 64;
  localparam int ACORN_CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DROP   = 2'd2,
    ST_RESULT = 2'd3
  } host_state_t;

  typedef enum logic [2:0] {
    SEL_KEY     = 3'd0,
    SEL_IV      = 3'd1,
    SEL_AD      = 3'd2,
    SEL_TEXT    = 3'd3,
    SEL_EXP_TAG = 3'd4,
    SEL_LEN     = 3'd5,
    SEL_RSVD6   = 3'd6,
    SEL_RSVD7   = 3'd7
  } wr_sel_t;

endpackage

// File: rtl/acorn128_word_stage.sv
// ---------------------------------------------------------------------------
// acorn128_word_stage
//   One staging register of BLK_W bits loaded WORD_W bits at a time.
//   Word idx 0 maps to bits [WORD_W-1:0]. Indices beyond the last word of
//   the register are ignored.
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the register
//   we     in   write enable for this field
//   idx    in   word index
//   data   in   word data
//   q      out  full register contents
// ---------------------------------------------------------------------------
module acorn128_word_stage #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] data,
  output logic [BLK_W-1:0]  q
);

  localparam int N_WORDS = BLK_W / WORD_W;

  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q <= '0;
        end else if (we && (idx == IDX_W'(gi))) begin
          word_q <= data;
        end
      end

      assign q[gi*WORD_W +: WORD_W] = word_q;
    end
  endgenerate

endmodule

// File: rtl/acorn128_host_if.sv
// ---------------------------------------------------------------------------
// acorn128_host_if
//   Host-side front end for acorn128_top. The host loads key, IV, AD, text,
//   length (and optionally an expected tag) as word writes; a command then
//   holds core_start high until the core reports ready, captures the core's
//   ciphertext and tag, drops start for one cycle so the core re-arms, and
//   offers the result on a valid/ready port.
//
//   Optional feature macro: TAG_VERIFY_EN
//     defined   : exp_tag staging register is built; decrypt results carry
//                 res_tag_ok = (core_tag == exp_tag) and res_data is zeroed
//                 on a mismatch.
//     undefined : wr_sel 4 writes complete but are discarded; res_tag_ok = 1.
//
// Ports
//   clk, rst_n                    clock / async active-low reset
//   wr_valid/wr_ready             host word write handshake (IDLE only)
//   wr_sel, wr_idx, wr_data       field select, word index, data
//   cmd_valid/cmd_ready           start-operation handshake
//   cmd_encrypt                   1 encrypt, 0 decrypt
//   core_start, core_encrypt      control to acorn128_top
//   core_key/iv/ad/text, core_len staging registers to acorn128_top
//   core_ready, core_ct, core_tag status/results from acorn128_top
//   res_valid/res_ready           result handshake
//   res_data, res_tag             captured ciphertext / tag
//   res_err                       1 = operation aborted by timeout
//   res_tag_ok                    tag verification outcome
//   busy                          operation in progress
// ---------------------------------------------------------------------------
module acorn128_host_if
  import acorn128_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 4000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [2:0]             wr_sel,
  input  logic [1:0]             wr_idx,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_encrypt,
  output logic                   core_start,
  output logic                   core_encrypt,
  output logic [ACORN_BLK_W-1:0] core_key,
  output logic [ACORN_BLK_W-1:0] core_iv,
  output logic [ACORN_BLK_W-1:0] core_ad,
  output logic [ACORN_BLK_W-1:0] core_text,
  output logic [ACORN_LEN_W-1:0] core_len,
  input  logic                   core_ready,
  input  logic [ACORN_BLK_W-1:0] core_ct,
  input  logic [ACORN_BLK_W-1:0] core_tag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACORN_BLK_W-1:0] res_data,
  output logic [ACORN_BLK_W-1:0] res_tag,
  output logic                   res_err,
  output logic                   res_tag_ok,
  output logic                   busy
);

  host_state_t            state_q;
  logic                   core_start_q;
  logic                   core_encrypt_q;
  logic [ACORN_CNT_W-1:0] cnt_q;
  logic                   res_valid_q;
  logic [ACORN_BLK_W-1:0] res_data_q;
  logic [ACORN_BLK_W-1:0] res_tag_q;
  logic                   res_err_q;

  logic                   in_idle;
  logic                   wr_fire;
  logic                   cmd_fire;
  logic                   timeout_hit;
  logic [ACORN_BLK_W-1:0] cap_data_d;

  // ------------------------------------------------------------------
  // Host handshakes. A pending write blocks the command for that cycle,
  // so a command issued together with a write runs on the updated data.
  // ------------------------------------------------------------------
  assign in_idle   = (state_q == ST_IDLE);
  assign wr_ready  = in_idle;
  assign cmd_ready = in_idle && !wr_valid;
  assign wr_fire   = in_idle && wr_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = !in_idle;

  assign timeout_hit = (cnt_q == ACORN_CNT_W'(TIMEOUT_CYC - 1));

  // ------------------------------------------------------------------
  // Staging registers
  // ------------------------------------------------------------------
  acorn128_word_stage #(.WORD_W(WORD_W), .BLK_W(ACORN_BLK_W), .IDX_W(2)) u_key (
    .clk(clk), .rst_n(rst_n), .we(wr_fire && (wr_sel == SEL_KEY)),
    .idx(wr_idx), .data(wr_data), .q(core_key)
  );

  acorn128_word_stage #(.WORD_W(WORD_W), .BLK_W(ACORN_BLK_W), .IDX_W(2)) u_iv (
    .clk(clk), .rst_n(rst_n), .we(wr_fire && (wr_sel == SEL_IV)),
    .idx(wr_idx), .data(wr_data), .q(core_iv)
  );

  acorn128_word_stage #(.WORD_W(WORD_W), .BLK_W(ACORN_BLK_W), .IDX_W(2)) u_ad (
    .clk(clk), .rst_n(rst_n), .we(wr_fire && (wr_sel == SEL_AD)),
    .idx(wr_idx), .data(wr_data), .q(core_ad)
  );

  acorn128_word_stage #(.WORD_W(WORD_W), .BLK_W(ACORN_BLK_W), .IDX_W(2)) u_text (
    .clk(clk), .rst_n(rst_n), .we(wr_fire && (wr_sel == SEL_TEXT)),
    .idx(wr_idx), .data(wr_data), .q(core_text)
  );

  // Length is 64 bits wide, so only the low word indices land.
  acorn128_word_stage #(.WORD_W(WORD_W), .BLK_W(ACORN_LEN_W), .IDX_W(2)) u_len (
    .clk(clk), .rst_n(rst_n), .we(wr_fire && (wr_sel == SEL_LEN)),
    .idx(wr_idx), .data(wr_data), .q(core_len)
  );

`ifdef TAG_VERIFY_EN
  logic [ACORN_BLK_W-1:0] exp_tag;
  logic                   cap_tag_ok_d;
  logic                   res_tag_ok_q;

  acorn128_word_stage #(.WORD_W(WORD_W), .BLK_W(ACORN_BLK_W), .IDX_W(2)) u_exp_tag (
    .clk(clk), .rst_n(rst_n), .we(wr_fire && (wr_sel == SEL_EXP_TAG)),
    .idx(wr_idx), .data(wr_data), .q(exp_tag)
  );

  // Encrypt has nothing to verify; decrypt must match the expected tag.
  assign cap_tag_ok_d = core_encrypt_q || (core_tag == exp_tag);
  // Unauthenticated plaintext is never released.
  assign cap_data_d   = cap_tag_ok_d ? core_ct : '0;
  assign res_tag_ok   = res_tag_ok_q;
`else
  assign cap_data_d   = core_ct;
  assign res_tag_ok   = 1'b1;
`endif

  // ------------------------------------------------------------------
  // Operation FSM with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      core_start_q   <= 1'b0;
      core_encrypt_q <= 1'b0;
      cnt_q          <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_tag_q      <= '0;
      res_err_q      <= 1'b0;
`ifdef TAG_VERIFY_EN
      res_tag_ok_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            state_q        <= ST_RUN;
            core_start_q   <= 1'b1;
            core_encrypt_q <= cmd_encrypt;
            cnt_q          <= '0;
          end
        end

        ST_RUN: begin
          // core_ready is checked first so a ready arriving on the
          // timeout cycle still yields a good result.
          if (core_ready) begin
            res_data_q   <= cap_data_d;
            res_tag_q    <= core_tag;
            res_err_q    <= 1'b0;
`ifdef TAG_VERIFY_EN
            res_tag_ok_q <= cap_tag_ok_d;
`endif
            core_start_q <= 1'b0;
            state_q      <= ST_DROP;
          end else if (timeout_hit) begin
            res_data_q   <= '0;
            res_tag_q    <= '0;
            res_err_q    <= 1'b1;
`ifdef TAG_VERIFY_EN
            // A decrypt that never finished is not authenticated.
            res_tag_ok_q <= core_encrypt_q;
`endif
            core_start_q <= 1'b0;
            state_q      <= ST_DROP;
          end else begin
            cnt_q <= cnt_q + ACORN_CNT_W'(1);
          end
        end

        // One full cycle with start low lets the core fall back to WAITING.
        ST_DROP: begin
          state_q     <= ST_RESULT;
          res_valid_q <= 1'b1;
        end

        ST_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          core_start_q <= 1'b0;
          res_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core_start   = core_start_q;
  assign core_encrypt = core_encrypt_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_tag      = res_tag_q;
  assign res_err      = res_err_q;

endmodule

// File: tb/tb_acorn128_host_if.sv
// ---------------------------------------------------------------------------
// tb_acorn128_host_if
//   Directed-plus-random bench for acorn128_host_if. A stub core answers
//   after a programmable latency (or never) with results derived from the
//   staging registers; the expected results come from the bench's own copy
//   of the host-written words.
// ---------------------------------------------------------------------------
module tb_acorn128_host_if;

  localparam int TO = 600;
`ifdef TAG_VERIFY_EN
  localparam bit TV = 1'b1;
`else
  localparam bit TV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [2:0]   wr_sel = '0;
  logic [1:0]   wr_idx = '0;
  logic [31:0]  wr_data = '0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_encrypt = 1'b0;
  logic         core_start;
  logic         core_encrypt;
  logic [127:0] core_key, core_iv, core_ad, core_text;
  logic [63:0]  core_len;
  logic         core_ready;
  logic [127:0] core_ct, core_tag;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data, res_tag;
  logic         res_err;
  logic         res_tag_ok;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // model of host-visible staging contents
  logic [31:0] m_key[4], m_iv[4], m_ad[4], m_text[4], m_exp[4], m_len[2];

  // stub core controls
  int stub_lat = 0;
  bit stub_hang = 1'b0;
  int stub_cnt = 0;

  always #5 clk = ~clk;

  acorn128_host_if #(.WORD_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_encrypt(cmd_encrypt),
    .core_start(core_start), .core_encrypt(core_encrypt),
    .core_key(core_key), .core_iv(core_iv), .core_ad(core_ad), .core_text(core_text), .core_len(core_len),
    .core_ready(core_ready), .core_ct(core_ct), .core_tag(core_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .res_err(res_err), .res_tag_ok(res_tag_ok), .busy(busy)
  );

  function automatic logic [127:0] f_ct(input logic [127:0] k, input logic [127:0] iv, input logic [127:0] t);
    return k ^ t ^ {iv[95:0], iv[127:96]};
  endfunction

  function automatic logic [127:0] f_tag(input logic [127:0] ad, input logic [127:0] iv,
                                         input logic [63:0] len, input logic enc);
    return ad ^ iv ^ {len, len} ^ {128{enc}};
  endfunction

  function automatic logic [127:0] pk(input logic [31:0] a[4]);
    return {a[3], a[2], a[1], a[0]};
  endfunction

  // stub core: ready from the stub_lat-th cycle of a held start
  always_ff @(posedge clk) begin
    if (!core_start) stub_cnt <= 0;
    else             stub_cnt <= stub_cnt + 1;
  end
  assign core_ready = core_start && !stub_hang && (stub_cnt >= stub_lat);
  assign core_ct    = f_ct(core_key, core_iv, core_text);
  assign core_tag   = f_tag(core_ad, core_iv, core_len, core_encrypt);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0; m_iv[i] = '0; m_ad[i] = '0; m_text[i] = '0; m_exp[i] = '0;
    end
    m_len[0] = '0; m_len[1] = '0;
  endtask

  task automatic model_write(input logic [2:0] sel, input logic [1:0] idx, input logic [31:0] d);
    case (sel)
      3'd0: m_key[idx]  = d;
      3'd1: m_iv[idx]   = d;
      3'd2: m_ad[idx]   = d;
      3'd3: m_text[idx] = d;
      3'd4: if (TV) m_exp[idx] = d;
      3'd5: if (idx < 2) m_len[idx[0]] = d;
      default: ;
    endcase
  endtask

  // called at a negedge; returns at the next negedge
  task automatic do_write(input logic [2:0] sel, input logic [1:0] idx, input logic [31:0] d);
    wr_sel = sel; wr_idx = idx; wr_data = d; wr_valid = 1'b1;
    #1 check("wr_ready", wr_ready, 1'b1);
    check("cmd_ready_blocked", cmd_ready, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    model_write(sel, idx, d);
    $display("[TB] write sel=%0d idx=%0d data=%08h", sel, idx, d);
  endtask

  task automatic write_blk(input logic [2:0] sel, input logic [127:0] v);
    for (int i = 0; i < 4; i++) do_write(sel, 2'(i), v[i*32 +: 32]);
  endtask

  task automatic run_op(input logic enc, input int lat, input bit hang, input int hold);
    logic [127:0] e_ct, e_tag, e_data;
    logic [63:0]  e_len;
    logic         e_ok, e_err;
    int           n, e_run;
    e_len = {m_len[1], m_len[0]};
    e_ct  = f_ct(pk(m_key), pk(m_iv), pk(m_text));
    e_tag = f_tag(pk(m_ad), pk(m_iv), e_len, enc);
    e_err = hang || (lat > TO - 1);
    e_run = e_err ? TO : lat + 1;
    if (e_err) begin
      e_ok = TV ? enc : 1'b1; e_data = '0; e_tag = '0;
    end else begin
      e_ok = TV ? (enc || (e_tag == pk(m_exp))) : 1'b1;
      e_data = (TV && !e_ok) ? '0 : e_ct;
    end
    stub_lat = lat; stub_hang = hang;
    cmd_encrypt = enc; cmd_valid = 1'b1;
    #1 check("cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("start_rise", core_start, 1'b1);
    check("busy_run", busy, 1'b1);
    check("core_encrypt", core_encrypt, enc);
    check("core_key", core_key, pk(m_key));
    check("core_text", core_text, pk(m_text));
    check("core_len", core_len, e_len);
    n = 0;
    while (core_start === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("run_cycles", n, e_run);
    check("drop_start_low", core_start, 1'b0);
    check("drop_no_valid", res_valid, 1'b0);
    @(negedge clk);
    check("res_valid", res_valid, 1'b1);
    check("res_data", res_data, e_data);
    check("res_tag", res_tag, e_tag);
    check("res_err", res_err, e_err);
    check("res_tag_ok", res_tag_ok, e_ok);
    for (int i = 0; i < hold; i++) begin
      // writes and commands must be refused while a result is pending
      wr_valid = 1'b1; wr_sel = 3'($urandom_range(0, 5)); wr_idx = 2'($urandom_range(0, 3));
      wr_data = $urandom; cmd_valid = 1'b1;
      #1 check("hold_wr_ready", wr_ready, 1'b0);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
      check("hold_valid", res_valid, 1'b1);
      check("hold_data", res_data, e_data);
      check("hold_tag", res_tag, e_tag);
    end
    wr_valid = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_fall", res_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    $display("[TB] op enc=%0d lat=%0d hang=%0d run=%0d data=%0h err=%0d ok=%0d",
             enc, lat, hang, n, res_data, res_err, res_tag_ok);
  endtask

  initial begin
    logic [127:0] t;
    model_clear();
    // reset state
    repeat (3) @(negedge clk);
    check("rst_start", core_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", res_valid, 1'b0);
    check("rst_data", res_data, 128'd0);
    check("rst_tag", res_tag, 128'd0);
    check("rst_err", res_err, 1'b0);
    check("rst_tag_ok", res_tag_ok, TV ? 1'b0 : 1'b1);
    check("rst_key", core_key, 128'd0);
    check("rst_len", core_len, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all-zero key/iv/ad/text, len 16, encrypt
    write_blk(3'd0, 128'd0); write_blk(3'd1, 128'd0);
    write_blk(3'd2, 128'd0); write_blk(3'd3, 128'd0);
    do_write(3'd5, 2'd0, 32'd16); do_write(3'd5, 2'd1, 32'd0);
    run_op(1'b1, 40, 1'b0, 0);

    // 2: random data, decrypt, result held for 50 cycles
    for (int i = 0; i < 4; i++) begin
      do_write(3'd0, 2'(i), $urandom); do_write(3'd3, 2'(i), $urandom);
      do_write(3'd1, 2'(i), $urandom);
    end
    run_op(1'b0, 77, 1'b0, 50);

    // 3: write and command together -> write wins, command then sees new key
    wr_sel = 3'd0; wr_idx = 2'd0; wr_data = 32'hDEADBEEF; wr_valid = 1'b1; cmd_valid = 1'b1;
    #1 check("simul_cmd_ready", cmd_ready, 1'b0);
    check("simul_busy", busy, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    model_write(3'd0, 2'd0, 32'hDEADBEEF);
    check("key_word0", core_key[31:0], 32'hDEADBEEF);
    run_op(1'b1, 10, 1'b0, 1);

    // boundary: ready on the timeout cycle -> core wins
    run_op(1'b1, TO - 1, 1'b0, 0);
    // boundary: ready never -> timeout after TO run cycles
    run_op(1'b1, 0, 1'b1, 2);
    // length high-word indices are ignored; reserved selects complete harmlessly
    do_write(3'd5, 2'd2, 32'h12345678); do_write(3'd6, 2'd1, 32'hCAFE0000);
    do_write(3'd7, 2'd3, 32'h0BADF00D);
    run_op(1'b0, 0, 1'b0, 0);

    // randomized operations
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < int'($urandom_range(3, 8)); w++)
        do_write(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 200)), 1'b0, int'($urandom_range(0, 4)));
    end

    // 5: async reset 500 cycles into RUN
    stub_hang = 1'b1; cmd_encrypt = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_run_start", core_start, 1'b1);
    repeat (500) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst_start", core_start, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_key", core_key, 128'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; stub_hang = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("arst_no_result", res_valid, 1'b0);
    end
    $display("[TB] async reset mid-RUN applied");

    // 6: decrypt with wrong then correct expected tag
    write_blk(3'd2, {$urandom, $urandom, $urandom, $urandom});
    write_blk(3'd1, {$urandom, $urandom, $urandom, $urandom});
    t = f_tag(pk(m_ad), pk(m_iv), {m_len[1], m_len[0]}, 1'b0);
    write_blk(3'd4, t ^ (128'd1 << $urandom_range(0, 127)));
    run_op(1'b0, 25, 1'b0, 0);
    write_blk(3'd4, t);
    run_op(1'b0, 25, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
